// File: rtl/mux_arb_pkg.sv
// Shared types and elaboration helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  // Default widths used when the arbiter and its interface are left unparameterised.
  localparam int unsigned DefWidth     = 8;
  localparam int unsigned DefSelWidth  = 3;
  localparam int unsigned DefNumInputs = 8;

  // IDLE: free arbitration. LOCKED: grant held by out_sel until its last beat.
  typedef enum logic [0:0] {
    ArbIdle   = 1'b0,
    ArbLocked = 1'b1
  } arb_state_t;

  // True when a select of sel_width bits can address every one of num_inputs requesters.
  function automatic bit sel_width_ok(int unsigned num_inputs, int unsigned sel_width);
    return (num_inputs >= 1) && (sel_width >= 1) && (sel_width < 32) &&
           (sel_width >= unsigned'($clog2(num_inputs)));
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester and downstream handshake bundle of the round-robin mux arbiter.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH      = mux_arb_pkg::DefWidth,
  parameter int unsigned SEL_WIDTH  = mux_arb_pkg::DefSelWidth,
  parameter int unsigned NUM_INPUTS = mux_arb_pkg::DefNumInputs
) ();

  logic [NUM_INPUTS-1:0] req_valid;
  logic [NUM_INPUTS-1:0] req_last;
  logic [WIDTH-1:0]      req_data [NUM_INPUTS];
  logic [NUM_INPUTS-1:0] req_ready;

  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic                  out_last;
  logic [SEL_WIDTH-1:0]  out_sel;
  logic                  out_ready;
  logic                  locked;

  // Producer/consumer side: drives requests and the downstream accept.
  modport master (
    output req_valid, req_last, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_sel, locked
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_last, req_data, out_ready,
    output req_ready, out_valid, out_data, out_last, out_sel, locked
  );

endinterface

// File: rtl/rr_priority_pick.sv
// Round-robin pick: first set request after rr_ptr_i, wrapping modulo NUM_INPUTS.
module rr_priority_pick #(
  parameter int unsigned SEL_WIDTH  = 3,
  parameter int unsigned NUM_INPUTS = 8
) (
  input  logic [NUM_INPUTS-1:0] req_i,
  input  logic [SEL_WIDTH-1:0]  rr_ptr_i,
  output logic [SEL_WIDTH-1:0]  grant_o,
  output logic                  any_grant_o
);

  logic [NUM_INPUTS-1:0] rotated;
  logic [SEL_WIDTH:0]    shamt;
  int unsigned           first;

  // Rotate so bit 0 is requester rr_ptr+1, find-first, then map back to a requester id.
  always_comb begin
    // rr_ptr is at most NUM_INPUTS-1, so a shift of NUM_INPUTS means "no rotation".
    shamt       = (SEL_WIDTH+1)'(rr_ptr_i) + (SEL_WIDTH+1)'(1);
    rotated     = NUM_INPUTS'({req_i, req_i} >> shamt);
    first       = 0;
    any_grant_o = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!any_grant_o && rotated[i]) begin
        any_grant_o = 1'b1;
        first       = unsigned'(i);
      end
    end
    grant_o = SEL_WIDTH'((unsigned'(int'(rr_ptr_i)) + 1 + first) % NUM_INPUTS);
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter with registered output stage over one shared WIDTH-bit mux.
// Multi-beat packets keep the grant until the winner's last beat is accepted.
module rr_mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned SEL_WIDTH  = DefSelWidth,
  parameter int unsigned NUM_INPUTS = DefNumInputs
) (
  input logic             clk,
  input logic             rst_n,
  rr_mux_arbiter_if.slave bus_io
);

  if (!sel_width_ok(NUM_INPUTS, SEL_WIDTH)) begin : g_bad_sel_width
    $error("rr_mux_arbiter: NUM_INPUTS does not fit in SEL_WIDTH bits");
  end

  arb_state_t           state_q;
  logic [SEL_WIDTH-1:0] rr_ptr_q;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic                 out_last_q;
  logic [SEL_WIDTH-1:0] out_sel_q;

  logic                 slot_free;
  logic [SEL_WIDTH-1:0] pick_id;
  logic                 pick_any;
  logic [SEL_WIDTH-1:0] grant_id;
  logic                 grant_any;
  logic                 accept;

  rr_priority_pick #(
    .SEL_WIDTH  (SEL_WIDTH),
    .NUM_INPUTS (NUM_INPUTS)
  ) u_pick (
    .req_i       (bus_io.req_valid),
    .rr_ptr_i    (rr_ptr_q),
    .grant_o     (pick_id),
    .any_grant_o (pick_any)
  );

  // Grant selection: free round-robin when idle, only the packet owner when locked.
  always_comb begin
    slot_free = !out_valid_q || bus_io.out_ready;
    if (state_q == ArbLocked) begin
      grant_id  = out_sel_q;
      grant_any = bus_io.req_valid[out_sel_q];
    end else begin
      grant_id  = pick_id;
      grant_any = pick_any;
    end
    accept = slot_free && grant_any;
  end

  assign bus_io.req_ready = accept ? (NUM_INPUTS'(1) << grant_id) : '0;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_data  = out_data_q;
  assign bus_io.out_last  = out_last_q;
  assign bus_io.out_sel   = out_sel_q;
  assign bus_io.locked    = (state_q == ArbLocked);

  // FSM, round-robin pointer and output register; everything moves only when the slot frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ArbIdle;
      rr_ptr_q    <= SEL_WIDTH'(NUM_INPUTS - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
    end else if (slot_free) begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= bus_io.req_data[grant_id];
        out_last_q  <= bus_io.req_last[grant_id];
        out_sel_q   <= grant_id;
        rr_ptr_q    <= grant_id;
        state_q     <= bus_io.req_last[grant_id] ? ArbIdle : ArbLocked;
      end else begin
        // Data and select keep their last value; only valid drops.
        out_valid_q <= 1'b0;
      end
    end
  end

  // Output id is always a real requester.
  a_sel_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q |-> (int'(out_sel_q) < int'(NUM_INPUTS)));

  // At most one requester is granted.
  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus_io.req_ready));

  // A stalled beat must not change.
  a_out_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !bus_io.out_ready) |=>
      (out_valid_q && $stable(out_data_q) && $stable(out_sel_q) && $stable(out_last_q)));

endmodule
